// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Latches the winning byte, pulses tx_start, then follows the transmitter through
// busy and back to idle. Optional burst lock keeps the grant until req_last.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned LOCK_BURST  = 1,
  parameter int unsigned ACK_TIMEOUT = 16,
  localparam int unsigned IdW        = $clog2(NUM_REQ),
  localparam int unsigned CntW       = $clog2(ACK_TIMEOUT)
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [WORD_WIDTH-1:0]         tx_data_out,
  output logic                          tx_start,
  input  logic                          tx_ready,
  output logic [IdW-1:0]                grant_id,
  output logic                          busy,
  output logic                          tx_timeout
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitAck, StWaitDone} state_e;

  localparam logic [IdW-1:0]  LastIdx = IdW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] AckLast = CntW'(ACK_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] hold_q;
  logic [IdW-1:0]        last_grant_q;
  logic [IdW-1:0]        grant_q;
  logic                  lock_q;
  logic                  timeout_q;
  logic                  timeout_set;

  logic                  win_found;
  logic [IdW-1:0]        win_idx;
  logic                  accept;

  // Winner search: upward from last_grant+1 with wrap; only last_grant while locked.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    if (lock_q) begin
      win_found = req_valid[last_grant_q];
      win_idx   = last_grant_q;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(last_grant_q) + k) % NUM_REQ;
        if (!win_found && req_valid[idx]) begin
          win_found = 1'b1;
          win_idx   = idx[IdW-1:0];
        end
      end
    end
  end

  // Gated by rst so req_ready stays at its reset value while reset is held.
  assign accept = (state_q == StIdle) && tx_ready && win_found && !rst;

  // One-hot ready for the current winner.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state, start pulse and ack-timeout counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_start    = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StLaunch;
      end
      StLaunch: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = StWaitAck;
      end
      StWaitAck: begin
        if (!tx_ready) begin
          state_d = StWaitDone;
        end else if (cnt_q == AckLast) begin
          // Transmitter never took the byte; drop it and free the arbiter.
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte capture, round-robin pointer, burst lock and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (rst) begin
      hold_q       <= '0;
      last_grant_q <= LastIdx;
      grant_q      <= '0;
      lock_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      if (accept) begin
        hold_q       <= req_data[win_idx*WORD_WIDTH +: WORD_WIDTH];
        last_grant_q <= win_idx;
        grant_q      <= win_idx;
        lock_q       <= (LOCK_BURST != 0) && !req_last[win_idx];
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
        lock_q    <= 1'b0;
      end
    end
  end

  assign tx_data_out = hold_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != StIdle);
  assign tx_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with burst lock, one without.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic        tx_ready = 1'b1;

  logic [3:0]  a_req_ready, b_req_ready;
  logic [7:0]  a_tx_data_out, b_tx_data_out;
  logic        a_tx_start, b_tx_start;
  logic [1:0]  a_grant_id, b_grant_id;
  logic        a_busy, b_busy;
  logic        a_tx_timeout, b_tx_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ(4), .WORD_WIDTH(8), .LOCK_BURST(1), .ACK_TIMEOUT(16)
  ) u_dut_lock (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(a_req_ready), .tx_data_out(a_tx_data_out),
    .tx_start(a_tx_start), .tx_ready(tx_ready), .grant_id(a_grant_id),
    .busy(a_busy), .tx_timeout(a_tx_timeout)
  );

  uart_tx_arbiter #(
    .NUM_REQ(4), .WORD_WIDTH(8), .LOCK_BURST(0), .ACK_TIMEOUT(16)
  ) u_dut_nolock (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(b_req_ready), .tx_data_out(b_tx_data_out),
    .tx_start(b_tx_start), .tx_ready(tx_ready), .grant_id(b_grant_id),
    .busy(b_busy), .tx_timeout(b_tx_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[i*8 +: 8] = b;
  endtask

  // From a LAUNCH window: ack by dropping tx_ready, then release it; ends in IDLE.
  task automatic finish_byte();
    tick();
    tx_ready = 1'b0;
    tick();
    tick();
    tx_ready = 1'b1;
    tick();
  endtask

  initial begin
    int acc[$];
    int hold_cnt;

    // Reset state, with inputs active to show they are ignored.
    rst = 1'b1;
    req_valid = 4'b1111;
    tx_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(a_req_ready), 32'h0);
    check("rst_tx_start", 32'(a_tx_start), 32'h0);
    check("rst_tx_data", 32'(a_tx_data_out), 32'h0);
    check("rst_grant", 32'(a_grant_id), 32'h0);
    check("rst_busy", 32'(a_busy | b_busy), 32'h0);
    check("rst_timeout", 32'(a_tx_timeout), 32'h0);

    // 1: single byte from requester 0.
    req_valid = 4'b0001;
    set_byte(0, 8'hA5);
    req_last = 4'b1111;
    rst = 1'b0;
    #1;
    check("t1_req_ready", 32'(a_req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t1_tx_start", 32'(a_tx_start), 32'h1);
    check("t1_tx_data", 32'(a_tx_data_out), 32'hA5);
    check("t1_grant", 32'(a_grant_id), 32'h0);
    check("t1_ready_drop", 32'(a_req_ready), 32'h0);
    tick();
    check("t1_start_pulse", 32'(a_tx_start), 32'h0);
    tx_ready = 1'b0;
    tick();
    tick();
    check("t1_busy_done", 32'(a_busy), 32'h1);
    tx_ready = 1'b1;
    tick();
    check("t1_idle", 32'(a_busy), 32'h0);
    check("t1_data_hold", 32'(a_tx_data_out), 32'hA5);

    // 4: stall while the transmitter is not ready.
    tx_ready = 1'b0;
    req_valid = 4'b0001;
    set_byte(0, 8'h3C);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_ready", 32'(a_req_ready), 32'h0);
      check("t4_stall_start", 32'(a_tx_start), 32'h0);
      tick();
    end
    tx_ready = 1'b1;
    #1;
    check("t4_ready_rise", 32'(a_req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("t4_start", 32'(a_tx_start), 32'h1);
    check("t4_data", 32'(a_tx_data_out), 32'h3C);
    finish_byte();

    // 3: requester 2 burst of three while requester 0 stays valid.
    req_valid = 4'b0101;
    set_byte(0, 8'h55);
    set_byte(2, 8'h11);
    req_last = 4'b0001;
    #1;
    check("t3_ready_b0", 32'(a_req_ready), 32'h4);
    tick();
    check("t3_data_b0", 32'(a_tx_data_out), 32'h11);
    check("t3_grant_b0", 32'(a_grant_id), 32'h2);
    set_byte(2, 8'h22);
    finish_byte();
    #1;
    // Without the lock requester 0 would win here.
    check("t3_ready_b1", 32'(a_req_ready), 32'h4);
    tick();
    check("t3_data_b1", 32'(a_tx_data_out), 32'h22);
    check("t3_grant_b1", 32'(a_grant_id), 32'h2);
    set_byte(2, 8'h33);
    req_last = 4'b0101;
    finish_byte();
    #1;
    check("t3_ready_b2", 32'(a_req_ready), 32'h4);
    tick();
    check("t3_data_b2", 32'(a_tx_data_out), 32'h33);
    check("t3_grant_b2", 32'(a_grant_id), 32'h2);
    set_byte(2, 8'h44);
    finish_byte();
    #1;
    check("t3_ready_r0", 32'(a_req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("t3_data_r0", 32'(a_tx_data_out), 32'h55);
    check("t3_grant_r0", 32'(a_grant_id), 32'h0);
    finish_byte();

    // 5: transmitter never drops tx_ready after the start pulse.
    req_valid = 4'b0001;
    set_byte(0, 8'h77);
    req_last = 4'b1111;
    tick();
    req_valid = 4'b0000;
    check("t5_start", 32'(a_tx_start), 32'h1);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("t5_busy_before", 32'(a_busy), 32'h1);
    check("t5_flag_before", 32'(a_tx_timeout), 32'h0);
    tick();
    check("t5_idle_after", 32'(a_busy), 32'h0);
    check("t5_flag_set", 32'(a_tx_timeout), 32'h1);
    req_valid = 4'b0010;
    set_byte(1, 8'h99);
    #1;
    check("t5_next_ready", 32'(a_req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    check("t5_next_start", 32'(a_tx_start), 32'h1);
    check("t5_next_data", 32'(a_tx_data_out), 32'h99);
    finish_byte();
    check("t5_flag_sticky", 32'(a_tx_timeout), 32'h1);

    // 6: reset during WAIT_DONE.
    req_valid = 4'b1000;
    set_byte(3, 8'hEE);
    #1;
    check("t6_ready_r3", 32'(a_req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    tx_ready = 1'b0;
    tick();
    check("t6_busy", 32'(a_busy), 32'h1);
    rst = 1'b1;
    req_valid = 4'b1111;
    set_byte(0, 8'hC0);
    set_byte(1, 8'hC1);
    set_byte(2, 8'hC2);
    set_byte(3, 8'hC3);
    tx_ready = 1'b1;
    tick();
    check("t6_rst_busy", 32'(a_busy), 32'h0);
    check("t6_rst_data", 32'(a_tx_data_out), 32'h0);
    check("t6_rst_timeout", 32'(a_tx_timeout), 32'h0);
    check("t6_rst_ready", 32'(a_req_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("t6_first_ready", 32'(a_req_ready), 32'h1);
    tick();
    check("t6_first_grant", 32'(a_grant_id), 32'h0);
    check("t6_first_data", 32'(a_tx_data_out), 32'hC0);
    finish_byte();

    // 2: round robin without lock; req_last=0 would pin a locking arbiter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_last = 4'b0000;
    tx_ready = 1'b1;
    hold_cnt = 0;
    for (int cyc = 0; cyc < 300 && acc.size() < 5; cyc++) begin
      if (b_tx_start) begin
        tx_ready = 1'b0;
        hold_cnt = 10;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) tx_ready = 1'b1;
      end
      #1;
      for (int i = 0; i < 4; i++) if (b_req_ready[i]) acc.push_back(i);
      tick();
    end
    check("t2_accept_count", 32'(acc.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("t2_order", (i < acc.size()) ? 32'(acc[i]) : 32'hF, 32'(i % 4));
    end
    req_valid = 4'b0000;
    tx_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (byte in, start pulse, ready out) among NUM_REQ byte producers using round-robin arbitration.
- Each producer offers bytes on a valid/ready handshake.
- The arbiter latches the winning byte, pulses the transmitter start, then tracks the transmitter through busy and back to idle.
- Optional burst lock keeps the grant on one requester until it marks its last byte, so multi-byte messages are not interleaved.
- Sits between message sources (status reporter, debug dump, command responder) and the single uart_tx instance.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
WORD_WIDTH, 8, UART data word width.
LOCK_BURST, 1, 1 = hold grant until the accepted byte has req_last=1; 0 = re-arbitrate after every byte.
ACK_TIMEOUT, 16, max cycles to wait for tx_ready to drop after tx_start; minimum 2.

Ports:
clock  in  1  system clock.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  requester i has a byte.
req_data  in  NUM_REQ*WORD_WIDTH  byte of requester i is at bits [i*WORD_WIDTH +: WORD_WIDTH].
req_last  in  NUM_REQ  byte is the final one of requester i's burst.
req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] && req_ready[i].
tx_data_out  out  WORD_WIDTH  byte to transmitter; held stable from LAUNCH until return to IDLE.
tx_start  out  1  one-cycle start pulse to transmitter.
tx_ready  in  1  transmitter idle/able to accept.
grant_id  out  clog2(NUM_REQ)  index of the last accepted requester.
busy  out  1  high in any state other than IDLE.
tx_timeout  out  1  sticky flag: transmitter never acknowledged a start; cleared only by rst.

Behaviour:
Reset values:
- state IDLE.
- req_ready=0, tx_start=0, tx_data_out=0, grant_id=0, busy=0, tx_timeout=0.
- Lock cleared; round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.

Round-robin winner (combinational):
- Lowest-numbered valid requester found by searching upward from (last_grant+1) mod NUM_REQ, wrapping.
- When the lock is set, the candidate set is only requester last_grant.

req_ready:
- Combinational: asserted for the winner only, only when state==IDLE && tx_ready==1 && a winner exists.
- Never more than one bit high.

States:
IDLE:
- On a transfer: hold_reg <= req_data of the winner, last_grant <= winner, grant_id <= winner.
- Lock <= LOCK_BURST && !req_last[winner].
- Next state LAUNCH.
- With tx_ready=0, or no eligible valid, stay in IDLE.
- When locked and the locked requester drops valid, wait indefinitely; other requesters are not served.

LAUNCH (1 cycle):
- tx_start=1, tx_data_out=hold_reg.
- Next state WAIT_ACK; the ack counter clears.

WAIT_ACK:
- If tx_ready==0, go to WAIT_DONE.
- Otherwise increment the counter.
- When the counter reaches ACK_TIMEOUT-1 with tx_ready still 1: set tx_timeout, clear the lock, go to IDLE. The byte is dropped, not retried.

WAIT_DONE:
- When tx_ready==1, go to IDLE.

Latency and throughput:
- Accept to tx_start: exactly 1 cycle; tx_start is high in the cycle after the handshake.
- Next accept no earlier than the first cycle in which tx_ready is seen high in WAIT_DONE, plus 1.

Other rules:
- tx_data_out holds its value after returning to IDLE until the next accept.
- Requesters may change req_data freely except in the cycle the transfer occurs.
- Reset mid-operation: immediate return to the reset values. A byte already started in the transmitter is not tracked.

Test Plan:
1. Single byte: req_valid=0001, req_data[0]=0xA5, req_last=1, tx_ready=1.
   -> req_ready=0001 for 1 cycle; tx_start 1 cycle later with tx_data_out=0xA5; grant_id=0; busy until the tx_ready low→high cycle completes.
2. Round-robin, LOCK_BURST=0: all four requesters valid continuously, req_last=1, a model transmitter drops tx_ready for 10 cycles per byte.
   -> accept order 0,1,2,3,0; no requester is accepted twice in a row.
3. Burst lock: requester 2 sends 3 bytes 0x11,0x22,0x33 with req_last=0,0,1 while requester 0 is continuously valid.
   -> transmitted order 0x11,0x22,0x33, then requester 0's byte; grant_id=2 for the first three.
4. Stall: tx_ready=0 with req_valid=0001.
   -> req_ready stays 0 and no tx_start; tx_ready rises → accept that cycle, tx_start the next cycle.
5. Timeout: ACK_TIMEOUT=16, the transmitter holds tx_ready=1 after tx_start.
   -> IDLE 16 cycles after WAIT_ACK entry; tx_timeout=1 and stays 1; the next request is served normally.
6. Reset mid-byte: rst asserted during WAIT_DONE, then released with all requesters valid.
   -> outputs at reset values while rst is high; the first accept after release goes to requester 0.
